// File: rtl/imem_loader_if.sv
// Byte-stream receive side plus instruction-memory write port of the boot loader.
interface imem_loader_if #(
  parameter int ADDR_W = 12
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: turns a framed UART byte stream into 32-bit instruction-memory
// writes and holds the core in reset until a checksum-verified frame has landed.
module imem_loader #(
  parameter int DEPTH   = 128,
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 1000000
) (
  input  logic         clk,
  input  logic         reset_n,
  imem_loader_if.slave bus,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         cpu_hold
);
  localparam int WI_W  = $clog2(DEPTH + 1);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;
  localparam logic [7:0] MAGIC    = 8'hA5;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    csum_add = acc + b;
  endfunction

  logic [2:0]        state_r, state_s;
  logic [15:0]       len_r, len_s;
  logic [WI_W-1:0]   idx_r, idx_s;
  logic [1:0]        lane_r, lane_s;
  logic [7:0]        sum_r, sum_s;
  logic [23:0]       shift_r, shift_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              we_s;
  logic [ADDR_W-1:0] addr_s;
  logic [31:0]       wdata_s;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              busy_r, done_r, error_r, cpu_hold_r;

  // Frame parser: next state, word assembly, checksum and inter-byte timeout.
  always_comb begin
    state_s = state_r;
    len_s   = len_r;
    idx_s   = idx_r;
    lane_s  = lane_r;
    sum_s   = sum_r;
    shift_s = shift_r;
    cnt_s   = cnt_r;
    we_s    = 1'b0;
    addr_s  = mem_addr_r;
    wdata_s = mem_wdata_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        cnt_s = '0;
        if (bus.rx_valid && (bus.rx_data == MAGIC)) begin
          state_s = S_LEN_LO;
        end else begin
          state_s = state_r;
        end
      end
      S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: begin
        // An accepted byte always wins over a timeout expiring on the same edge.
        if (bus.rx_valid) begin
          cnt_s = '0;
          case (state_r)
            S_LEN_LO: begin
              len_s[7:0] = bus.rx_data;
              state_s    = S_LEN_HI;
            end
            S_LEN_HI: begin
              len_s[15:8] = bus.rx_data;
              idx_s       = '0;
              lane_s      = 2'd0;
              sum_s       = 8'd0;
              if ({bus.rx_data, len_r[7:0]} == 16'd0) begin
                state_s = S_CSUM;
              end else if ({bus.rx_data, len_r[7:0]} > 16'(DEPTH)) begin
                state_s = S_ERR;
              end else begin
                state_s = S_DATA;
              end
            end
            S_DATA: begin
              sum_s = csum_add(sum_r, bus.rx_data);
              case (lane_r)
                2'd0: begin shift_s[7:0]   = bus.rx_data; lane_s = 2'd1; end
                2'd1: begin shift_s[15:8]  = bus.rx_data; lane_s = 2'd2; end
                2'd2: begin shift_s[23:16] = bus.rx_data; lane_s = 2'd3; end
                default: begin
                  we_s    = 1'b1;
                  addr_s  = ADDR_W'({idx_r, 2'b00});
                  wdata_s = {bus.rx_data, shift_r};
                  lane_s  = 2'd0;
                  idx_s   = idx_r + WI_W'(1);
                  if (idx_r == WI_W'(len_r - 16'd1)) begin
                    state_s = S_CSUM;
                  end else begin
                    state_s = S_DATA;
                  end
                end
              endcase
            end
            default: begin
              if (bus.rx_data == sum_r) begin
                state_s = S_DONE;
              end else begin
                state_s = S_ERR;
              end
            end
          endcase
        end else if (cnt_r == CNT_W'(TIMEOUT)) begin
          state_s = S_ERR;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      len_r       <= 16'd0;
      idx_r       <= '0;
      lane_r      <= 2'd0;
      sum_r       <= 8'd0;
      shift_r     <= 24'd0;
      cnt_r       <= '0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      cpu_hold_r  <= 1'b1;
    end else begin
      state_r     <= state_s;
      len_r       <= len_s;
      idx_r       <= idx_s;
      lane_r      <= lane_s;
      sum_r       <= sum_s;
      shift_r     <= shift_s;
      cnt_r       <= cnt_s;
      mem_we_r    <= we_s;
      mem_addr_r  <= addr_s;
      mem_wdata_r <= wdata_s;
      busy_r      <= (state_s == S_LEN_LO) || (state_s == S_LEN_HI) ||
                     (state_s == S_DATA)   || (state_s == S_CSUM);
      done_r      <= (state_s == S_DONE);
      error_r     <= (state_s == S_ERR);
      cpu_hold_r  <= (state_s != S_DONE);
    end
  end

  assign bus.rx_ready  = 1'b1;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;
  assign cpu_hold      = cpu_hold_r;
endmodule
